// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and op timing for the RSA modular-exponentiation datapath.
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, TOMONT, INIT, SQR, MUL, FROMMONT, REDUCE, DONE} state_t;
  typedef enum logic [2:0] {CLR, LOAD, ITER, CAP, SAMPLE} mmm_phase_t;
  function automatic int op_cycles(input int w);
    return w + 3;
  endfunction
endpackage

// File: rtl/rsa_cond_sub.sv
// rsa_cond_sub: combinational x >= m ? x - m : x, borrow of a one-bit-wider subtract selects.
module rsa_cond_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH:0] diff;
  assign diff = {1'b0, x_i} - {1'b0, m_i};
  assign y_o  = diff[WIDTH] ? x_i : diff[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Define RSA_SKIP_LEADING_ZEROS_EN to skip exponent bits above the highest set bit.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 start,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     R2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     C,
  output logic                 mmm_clear,
  output logic                 mmm_ld_a,
  output logic                 mmm_ld_r,
  output logic                 mmm_lock,
  output logic [WIDTH-1:0]     mmm_a,
  output logic [WIDTH-1:0]     mmm_b,
  output logic [WIDTH-1:0]     mmm_m,
  input  logic [WIDTH-1:0]     mmm_r
);
  localparam int CW = $clog2(WIDTH + 4);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] N_CAP = CW'(op_cycles(WIDTH) - 1);
  localparam logic [CW-1:0] N_SMP = CW'(op_cycles(WIDTH));
  localparam logic [IW-1:0] I_TOP = IW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state_q, state_d;
  mmm_phase_t phase;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d, pm_q, pm_d, p_q, p_d, m_q, m_d, r2_q, r2_d, c_q, c_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic pend_q, pend_d, dst_pm_q, dst_pm_d, seen_q, seen_d;
  logic op_st, scan, active, cap, bit_i;
  logic [WIDTH-1:0] x_fwd, x_red;

  rsa_cond_sub #(.WIDTH(WIDTH)) u_sub (.x_i(x_q), .m_i(m_q), .y_o(x_red));

  // A result captured at CAP is forwarded straight from mmm_r in the following cycle,
  // so the next op can start without a separate sample cycle.
  always_comb begin
    op_st  = state_q inside {TOMONT, INIT, SQR, MUL, FROMMONT};
    bit_i  = e_q[idx_q];
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    scan   = state_q == SQR && cnt_q == '0 && !seen_q && !bit_i;
`else
    scan   = 1'b0;
`endif
    active = op_st && cnt_q <= N_CAP && !scan;
    phase  = cnt_q == '0 ? CLR : cnt_q == CW'(1) ? LOAD : cnt_q < N_CAP ? ITER : cnt_q == N_CAP ? CAP : SAMPLE;
    cap    = active && phase == CAP;
    x_fwd  = (pend_q && !dst_pm_q) ? mmm_r : x_q;
  end

  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      pm_q     <= '0;
      p_q      <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      c_q      <= '0;
      e_q      <= '0;
      pend_q   <= 1'b0;
      dst_pm_q <= 1'b0;
      seen_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      pm_q     <= pm_d;
      p_q      <= p_d;
      m_q      <= m_d;
      r2_q     <= r2_d;
      c_q      <= c_d;
      e_q      <= e_d;
      pend_q   <= pend_d;
      dst_pm_q <= dst_pm_d;
      seen_q   <= seen_d;
    end

  always_comb begin
    state_d  = state_q;
    cnt_d    = active ? cnt_q + 1'b1 : cnt_q;
    idx_d    = idx_q;
    x_d      = x_fwd;
    pm_d     = (pend_q && dst_pm_q) ? mmm_r : pm_q;
    p_d      = p_q;
    m_d      = m_q;
    r2_d     = r2_q;
    e_d      = e_q;
    c_d      = c_q;
    pend_d   = cap;
    dst_pm_d = cap ? state_q == TOMONT : dst_pm_q;
    seen_d   = seen_q | (state_q == SQR && !scan);
    unique case (state_q)
      IDLE: if (start) begin
        state_d = TOMONT;
        cnt_d   = '0;
        idx_d   = I_TOP;
        seen_d  = 1'b0;
        p_d     = P;
        e_d     = E;
        m_d     = M;
        r2_d    = R2;
      end
      TOMONT: if (cap) begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: if (cap) begin
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        state_d = |e_q ? SQR : FROMMONT;
`else
        state_d = SQR;
`endif
        cnt_d   = '0;
      end
      SQR: if (cap) begin
        state_d = bit_i ? MUL : idx_q == '0 ? FROMMONT : SQR;
        idx_d   = bit_i ? idx_q : idx_q - 1'b1;
        cnt_d   = '0;
      end else if (scan) idx_d = idx_q - 1'b1;
      MUL: if (cap) begin
        state_d = idx_q == '0 ? FROMMONT : SQR;
        idx_d   = idx_q - 1'b1;
        cnt_d   = '0;
      end
      FROMMONT: if (cnt_q == N_SMP) state_d = REDUCE;
      REDUCE: begin
        c_d     = x_red;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    C         = c_q;
    mmm_m     = m_q;
    mmm_lock  = !active;
    mmm_clear = active && phase == CLR && ena;
    mmm_ld_a  = active && phase == LOAD && ena;
    mmm_ld_r  = cap && ena;
    mmm_a     = !active ? '0 : state_q == TOMONT ? p_q : state_q == INIT ? ONE : x_fwd;
    mmm_b     = !active ? '0 : state_q inside {TOMONT, INIT} ? r2_q : state_q == SQR ? x_fwd : state_q == MUL ? pm_q : ONE;
  end
endmodule
